// File: rtl/jpeg_ring_adapter.sv
// rtl/jpeg_ring_adapter.sv - ring-to-jpeg_core bridge: skid-registered input beats, packed pixel output FIFO
module jpeg_ring_adapter #(
    parameter int RING_WIDTH = 88,
    parameter int FIFO_DEPTH = 4,
    parameter int PACK_MODE  = 0,
    localparam int PPW = RING_WIDTH / 24,
    localparam int CW  = $clog2(PPW + 1),
    localparam int LW  = $clog2(FIFO_DEPTH + 1),
    localparam int PW  = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ring_v_i,
    input  logic [RING_WIDTH-1:0] ring_data_i,
    output logic                  ring_yumi_o,
    output logic                  core_valid_o,
    output logic [31:0]           core_data_o,
    output logic [3:0]            core_strb_o,
    output logic                  core_last_o,
    input  logic                  core_accept_i,
    input  logic                  pix_valid_i,
    input  logic [15:0]           pix_width_i,
    input  logic [15:0]           pix_height_i,
    input  logic [15:0]           pix_x_i,
    input  logic [15:0]           pix_y_i,
    input  logic [7:0]            pix_r_i,
    input  logic [7:0]            pix_g_i,
    input  logic [7:0]            pix_b_i,
    output logic                  pix_accept_o,
    output logic                  out_v_o,
    output logic [RING_WIDTH-1:0] out_data_o,
    output logic [CW-1:0]         out_count_o,
    input  logic                  out_ready_i,
    output logic [LW-1:0]         fifo_level_o,
    output logic                  frame_done_o
);

    // ---------------- input path: one-entry skid register ----------------
    logic        r_hold_v;
    logic [31:0] r_core_data;
    logic [3:0]  r_core_strb;
    logic        r_core_last;
    logic        w_yumi;
    logic        w_unused_ring;

    // Only the low 37 bits of a ring word carry beat fields.
    assign w_unused_ring = ^ring_data_i[RING_WIDTH-1:37];

    // A new word may enter when the register is empty or its beat leaves this cycle.
    assign w_yumi      = ~rst_i & ring_v_i & (~r_hold_v | core_accept_i);
    assign ring_yumi_o = w_yumi;

    // Load the skid register on yumi, drop the beat when the core takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_v    <= 1'b0;
            r_core_data <= 32'd0;
            r_core_strb <= 4'd0;
            r_core_last <= 1'b0;
        end else if (w_yumi) begin
            r_hold_v    <= 1'b1;
            r_core_data <= ring_data_i[31:0];
            r_core_strb <= ring_data_i[35:32];
            r_core_last <= ring_data_i[36];
        end else if (core_accept_i) begin
            r_hold_v    <= 1'b0;
        end
    end

    assign core_valid_o = r_hold_v;
    assign core_data_o  = r_core_data;
    assign core_strb_o  = r_core_strb;
    assign core_last_o  = r_core_last;

    // ---------------- output FIFO ----------------
    logic [RING_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [CW-1:0]         r_mem_cnt  [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [RING_WIDTH-1:0] w_push_data;
    logic [CW-1:0]         w_push_cnt;

    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & out_ready_i;

    // Storage array; contents are don't-care until the level says an entry is live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_cnt[r_wr_ptr]  <= w_push_cnt;
        end
    end

    // Pointers wrap at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign out_v_o      = ~w_empty;
    assign out_data_o   = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign out_count_o  = w_empty ? '0 : r_mem_cnt[r_rd_ptr];
    assign fifo_level_o = r_level;

    // ---------------- pixel packing ----------------
    logic [RING_WIDTH-1:0] r_stage;
    logic [CW-1:0]         r_lane;
    logic                  r_frame_done;
    logic                  w_frame_end;
    logic                  w_lane_last;
    logic                  w_push_needed;
    logic                  w_pix_accept;

    // A zero-sized image has no last pixel, so the wrap of width-1 must not match.
    assign w_frame_end = (pix_width_i != 16'd0) && (pix_height_i != 16'd0)
                      && (pix_x_i == pix_width_i - 16'd1)
                      && (pix_y_i == pix_height_i - 16'd1);
    assign w_lane_last = (r_lane == CW'(PPW - 1));

    // Build the candidate word: full record, or staged lanes plus the incoming RGB lane.
    always_comb begin
        w_push_data   = '0;
        w_push_cnt    = CW'(1);
        w_push_needed = 1'b1;
        if (PACK_MODE == 0) begin
            w_push_data[87:0] = {pix_width_i, pix_height_i, pix_x_i, pix_y_i,
                                 pix_r_i, pix_g_i, pix_b_i};
        end else begin
            w_push_data = r_stage;
            for (int k = 0; k < PPW; k++) begin
                if (r_lane == CW'(k)) w_push_data[24*k +: 24] = {pix_r_i, pix_g_i, pix_b_i};
            end
            w_push_cnt    = r_lane + CW'(1);
            w_push_needed = w_lane_last | w_frame_end;
        end
    end

    // A pixel that only fills a lane never needs FIFO space.
    assign w_pix_accept = ~rst_i & pix_valid_i & ~(w_push_needed & w_full & ~w_pop);
    assign w_push       = w_pix_accept & w_push_needed;
    assign pix_accept_o = w_pix_accept;

    // Accumulate lanes between pushes; a push restarts packing at lane 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stage <= '0;
            r_lane  <= '0;
        end else if ((PACK_MODE != 0) && w_pix_accept) begin
            if (w_push) begin
                r_stage <= '0;
                r_lane  <= '0;
            end else begin
                r_stage <= w_push_data;
                r_lane  <= r_lane + CW'(1);
            end
        end
    end

    // Pulse once, the cycle after the frame's last pixel lands in the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_frame_done <= 1'b0;
        else       r_frame_done <= w_push & w_frame_end;
    end

    assign frame_done_o = r_frame_done;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full && !w_pop));

    a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (core_valid_o && !core_accept_i) |=>
            ($stable(core_data_o) && $stable(core_strb_o) && $stable(core_last_o)));

endmodule
